// File: rtl/btn_debounce_multi.sv
// N-channel push-button front end: 2-FF synchroniser, shared sample tick, shift-register
// debounce with hysteresis, and a per-channel press/long/repeat classifier.
module btn_debounce_multi #(
    parameter int N_BTN     = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 1_000,
    parameter int DEPTH     = 8,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int DIV    = CLK_HZ / SAMPLE_HZ;
    localparam int LONG_T = LONG_MS * SAMPLE_HZ / 1000;
    localparam int REP_T  = REPEAT_MS * SAMPLE_HZ / 1000;
    localparam int DIV_W  = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = ($clog2(LONG_T + 1) > 1) ? $clog2(LONG_T + 1) : 1;
    localparam int REP_W  = ($clog2(REP_T + 1) > 1) ? $clog2(REP_T + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [N_BTN-1:0] sync1_q, sync2_q;

    always_comb begin
        tick  = (div_q == DIV_W'(DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [DEPTH-1:0]  sh_q, sh_d;
        logic              level_q, level_d;
        logic [1:0]        state_q, state_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [REP_W-1:0]  rep_q, rep_d;
        logic              press_q, press_d, release_q, release_d;
        logic              long_q, long_d, repeat_q, repeat_d;
        logic              rise, fall;

        // Level only moves when the whole window agrees; mixed windows hold the old level.
        always_comb begin
            sh_d    = sh_q;
            level_d = level_q;
            if (tick) begin
                sh_d = {sh_q[DEPTH-2:0], sync2_q[g]};
                if (&sh_d) begin
                    level_d = 1'b1;
                end else if (~|sh_d) begin
                    level_d = 1'b0;
                end
            end
        end

        // Events are decided from level_d so they register in the same clk as the new level.
        always_comb begin
            rise      = level_d & ~level_q;
            fall      = ~level_d & level_q;
            state_d   = state_q;
            hold_d    = hold_q;
            rep_d     = rep_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall) begin
                        release_d = 1'b1;
                        hold_d    = '0;
                        rep_d     = '0;
                        state_d   = ST_IDLE;
                    end else if (tick) begin
                        if (hold_q == HOLD_W'(LONG_T - 1)) begin
                            long_d  = 1'b1;
                            rep_d   = '0;
                            state_d = ST_HELD;
                        end else if (~&hold_q) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        release_d = 1'b1;
                        hold_d    = '0;
                        rep_d     = '0;
                        state_d   = ST_IDLE;
                    end else if (tick && REP_T != 0) begin
                        if (rep_q == REP_W'(REP_T - 1)) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else if (~&rep_q) begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sh_q      <= '0;
                level_q   <= 1'b0;
                state_q   <= ST_IDLE;
                hold_q    <= '0;
                rep_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sh_q      <= sh_d;
                level_q   <= level_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
                rep_q     <= rep_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = repeat_q;
    end

endmodule
